// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: write port, two read ports, clear control and status.
//   master: Load, DR, Din, SR1, SR2, Clear -> ; <- SR1_out, SR2_out, Busy, Wr_drop
//   slave : mirror image, used by the register file itself.
// WIDTH and DEPTH must match the parameters of the reg_file_param instance on this bus.
interface reg_file_param_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              Load;
  logic [ADDR_W-1:0] DR;
  logic [WIDTH-1:0]  Din;
  logic [ADDR_W-1:0] SR1;
  logic [ADDR_W-1:0] SR2;
  logic [WIDTH-1:0]  SR1_out;
  logic [WIDTH-1:0]  SR2_out;
  logic              Clear;
  logic              Busy;
  logic              Wr_drop;

  modport master (
    output Load, DR, Din, SR1, SR2, Clear,
    input  SR1_out, SR2_out, Busy, Wr_drop
  );

  modport slave (
    input  Load, DR, Din, SR1, SR2, Clear,
    output SR1_out, SR2_out, Busy, Wr_drop
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file: DEPTH x WIDTH, one write port, two combinational read ports,
// optional same-cycle write-to-read bypass and a one-register-per-cycle bulk-clear engine.
// Ports:
//   Clk     - clock, rising edge
//   Reset_n - asynchronous active-low reset
//   bus     - reg_file_param_if slave: Load/DR/Din write, SR1/SR2 -> SR1_out/SR2_out reads,
//             Clear request, Busy while clearing, Wr_drop when a requested write is refused
module reg_file_param #(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      DEPTH     = 8,
  parameter bit               BYPASS    = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic             Clk,
  input logic             Reset_n,
  reg_file_param_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  // One extra bit so the range test also works when DEPTH is a power of two.
  localparam logic [ADDR_W:0]   DepthExt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(DEPTH - 1);

  typedef enum logic {StIdle, StClearing} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];

  logic dr_ok, sr1_ok, sr2_ok, wr_en;

  assign dr_ok  = ({1'b0, bus.DR}  < DepthExt);
  assign sr1_ok = ({1'b0, bus.SR1} < DepthExt);
  assign sr2_ok = ({1'b0, bus.SR2} < DepthExt);
  assign wr_en  = bus.Load && (state_q == StIdle) && dr_ok;

  assign bus.Busy    = (state_q == StClearing);
  assign bus.Wr_drop = bus.Load && !wr_en;

  // Next state: writes only land in idle, the sweep only runs while clearing, so the two
  // never target the file in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    unique case (state_q)
      StIdle: begin
        if (wr_en) begin
          regs_d[bus.DR] = bus.Din;
        end
        if (bus.Clear) begin
          state_d = StClearing;
          cnt_d   = '0;
        end
      end
      StClearing: begin
        regs_d[cnt_q] = RESET_VAL;
        if (cnt_q == LastIdx) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      regs_q  <= '{default: RESET_VAL};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

  // Read ports: out-of-range addresses read zero; bypass only follows accepted writes.
  always_comb begin
    bus.SR1_out = '0;
    if (sr1_ok) begin
      bus.SR1_out = regs_q[bus.SR1];
    end
    if (BYPASS && wr_en && (bus.SR1 == bus.DR)) begin
      bus.SR1_out = bus.Din;
    end
  end

  always_comb begin
    bus.SR2_out = '0;
    if (sr2_ok) begin
      bus.SR2_out = regs_q[bus.SR2];
    end
    if (BYPASS && wr_en && (bus.SR2 == bus.DR)) begin
      bus.SR2_out = bus.Din;
    end
  end
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: an 8-deep bypassing instance and a 6-deep non-bypassing instance.
// Expected read values come from bench-side register models and are queued before sampling.
module tb_reg_file_param;
  logic Clk;
  logic Reset_n;

  reg_file_param_if #(.WIDTH(16), .DEPTH(8)) b8 ();
  reg_file_param_if #(.WIDTH(16), .DEPTH(6)) b6 ();

  reg_file_param #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1), .RESET_VAL(16'h0000)) dut8 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(b8.slave)
  );
  reg_file_param #(.WIDTH(16), .DEPTH(6), .BYPASS(1'b0), .RESET_VAL(16'h0000)) dut6 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(b6.slave)
  );

  int          n_cmp;
  int          n_err;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;
  logic [15:0] model8[8];
  logic [15:0] model6[6];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr8(input int a, input logic [15:0] d);
    b8.Load = 1'b1; b8.DR = 3'(a); b8.Din = d;
    tick();
    b8.Load = 1'b0;
    model8[a] = d;
  endtask

  task automatic wr6(input int a, input logic [15:0] d);
    b6.Load = 1'b1; b6.DR = 3'(a); b6.Din = d;
    tick();
    b6.Load = 1'b0;
    model6[a] = d;
  endtask

  task automatic zero_models();
    for (int i = 0; i < 8; i++) model8[i] = 16'h0000;
    for (int i = 0; i < 6; i++) model6[i] = 16'h0000;
  endtask

  task automatic test_reset();
    wr8(2, 16'hABCD);
    wr8(7, 16'h7777);
    b8.SR1 = 3'd2; b8.SR2 = 3'd7;
    @(negedge Clk);
    Reset_n = 1'b0;
    zero_models();
    #1;
    exp_q.push_back(model8[2]); exp_q.push_back(model8[7]);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b8.SR1_out !== exp_v) begin
      n_err++; $display("FAIL reset_async_sr1 got=%h exp=%h", b8.SR1_out, exp_v);
    end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b8.SR2_out !== exp_v) begin
      n_err++; $display("FAIL reset_async_sr2 got=%h exp=%h", b8.SR2_out, exp_v);
    end
    n_cmp++;
    if (b8.Busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy got=%b exp=0", b8.Busy);
    end
    for (int i = 0; i < 8; i++) begin
      b8.SR1 = 3'(i); b8.SR2 = 3'(7 - i);
      #1;
      exp_q.push_back(model8[i]); exp_q.push_back(model8[7 - i]);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (b8.SR1_out !== exp_v) begin
        n_err++; $display("FAIL reset_sr1[%0d] got=%h exp=%h", i, b8.SR1_out, exp_v);
      end
      exp_v = exp_q.pop_front(); n_cmp++;
      if (b8.SR2_out !== exp_v) begin
        n_err++; $display("FAIL reset_sr2[%0d] got=%h exp=%h", 7 - i, b8.SR2_out, exp_v);
      end
    end
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    wr8(3, 16'hBEEF);
    wr8(5, 16'h1234);
    b8.SR1 = 3'd3; b8.SR2 = 3'd5;
    #1;
    exp_q.push_back(16'hBEEF); exp_q.push_back(16'h1234);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b8.SR1_out !== exp_v) begin
      n_err++; $display("FAIL readback_sr1 got=%h exp=%h", b8.SR1_out, exp_v);
    end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b8.SR2_out !== exp_v) begin
      n_err++; $display("FAIL readback_sr2 got=%h exp=%h", b8.SR2_out, exp_v);
    end
    // Bypass on SR1 while SR2 reads a non-matching address.
    b8.Load = 1'b1; b8.DR = 3'd3; b8.Din = 16'h0001;
    #1;
    exp_q.push_back(16'h0001); exp_q.push_back(16'h1234);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b8.SR1_out !== exp_v) begin
      n_err++; $display("FAIL bypass_sr1 got=%h exp=%h", b8.SR1_out, exp_v);
    end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b8.SR2_out !== exp_v) begin
      n_err++; $display("FAIL bypass_nomatch_sr2 got=%h exp=%h", b8.SR2_out, exp_v);
    end
    b8.SR2 = 3'd3;
    #1;
    exp_q.push_back(16'h0001);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b8.SR2_out !== exp_v) begin
      n_err++; $display("FAIL bypass_sr2 got=%h exp=%h", b8.SR2_out, exp_v);
    end
    n_cmp++;
    if (b8.Wr_drop !== 1'b0) begin
      n_err++; $display("FAIL wr_drop_idle got=%b exp=0", b8.Wr_drop);
    end
    tick();
    b8.Load = 1'b0;
    model8[3] = 16'h0001;
    #1;
    exp_q.push_back(model8[3]);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b8.SR1_out !== exp_v) begin
      n_err++; $display("FAIL after_write_sr1 got=%h exp=%h", b8.SR1_out, exp_v);
    end
    // Non-bypassing instance: old value this cycle, new value after the edge.
    wr6(3, 16'hBEEF);
    b6.SR1 = 3'd3; b6.Load = 1'b1; b6.DR = 3'd3; b6.Din = 16'h0001;
    #1;
    exp_q.push_back(16'hBEEF);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b6.SR1_out !== exp_v) begin
      n_err++; $display("FAIL nobypass_same_cycle got=%h exp=%h", b6.SR1_out, exp_v);
    end
    tick();
    b6.Load = 1'b0;
    model6[3] = 16'h0001;
    #1;
    exp_q.push_back(model6[3]);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b6.SR1_out !== exp_v) begin
      n_err++; $display("FAIL nobypass_next_cycle got=%h exp=%h", b6.SR1_out, exp_v);
    end
  endtask

  task automatic test_bulk_clear();
    for (int i = 0; i < 8; i++) wr8(i, 16'h00A0 + 16'(i));
    b8.Clear = 1'b1;
    tick();
    b8.Clear = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (b8.Busy !== 1'b1) begin
        n_err++; $display("FAIL clear_busy[%0d] got=%b exp=1", k, b8.Busy);
      end
      for (int j = 0; j < 4; j++) begin
        b8.SR1 = 3'(2 * j); b8.SR2 = 3'(2 * j + 1);
        #1;
        exp_q.push_back(model8[2 * j]); exp_q.push_back(model8[2 * j + 1]);
        exp_v = exp_q.pop_front(); n_cmp++;
        if (b8.SR1_out !== exp_v) begin
          n_err++; $display("FAIL clear_k%0d_reg%0d got=%h exp=%h", k, 2 * j, b8.SR1_out, exp_v);
        end
        exp_v = exp_q.pop_front(); n_cmp++;
        if (b8.SR2_out !== exp_v) begin
          n_err++;
          $display("FAIL clear_k%0d_reg%0d got=%h exp=%h", k, 2 * j + 1, b8.SR2_out, exp_v);
        end
      end
      tick();
      model8[k] = 16'h0000;
    end
    n_cmp++;
    if (b8.Busy !== 1'b0) begin
      n_err++; $display("FAIL clear_busy_end got=%b exp=0", b8.Busy);
    end
    for (int i = 0; i < 8; i++) begin
      b8.SR1 = 3'(i);
      #1;
      exp_q.push_back(16'h0000);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (b8.SR1_out !== exp_v) begin
        n_err++; $display("FAIL clear_done_reg%0d got=%h exp=%h", i, b8.SR1_out, exp_v);
      end
    end
  endtask

  task automatic test_write_during_clear();
    int n;
    for (int i = 0; i < 8; i++) wr8(i, 16'h00A0 + 16'(i));
    b8.Clear = 1'b1;
    tick();
    b8.Clear = 1'b0;
    tick(); model8[0] = 16'h0000;
    tick(); model8[1] = 16'h0000;
    // Third Busy cycle.
    b8.Load = 1'b1; b8.DR = 3'd6; b8.Din = 16'hFFFF; b8.SR1 = 3'd6;
    #1;
    n_cmp++;
    if (b8.Wr_drop !== 1'b1) begin
      n_err++; $display("FAIL wr_drop_clearing got=%b exp=1", b8.Wr_drop);
    end
    exp_q.push_back(model8[6]);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b8.SR1_out !== exp_v) begin
      n_err++; $display("FAIL no_bypass_dropped got=%h exp=%h", b8.SR1_out, exp_v);
    end
    tick();
    b8.Load = 1'b0;
    // Clear held mid-sweep must not restart or extend it.
    b8.Clear = 1'b1;
    tick();
    b8.Clear = 1'b0;
    n = 1;
    while (b8.Busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 5) begin
      n_err++; $display("FAIL clear_ignores_clear edges_after=%0d exp=5", n);
    end
    zero_models();
    for (int i = 0; i < 6; i++) model6[i] = 16'h0000;
    #1;
    exp_q.push_back(16'h0000);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b8.SR1_out !== exp_v) begin
      n_err++; $display("FAIL dropped_reg6_final got=%h exp=%h", b8.SR1_out, exp_v);
    end
  endtask

  task automatic test_load_and_clear();
    int n;
    for (int i = 1; i < 8; i++) wr8(i, 16'h0C00 + 16'(i));
    b8.Load = 1'b1; b8.DR = 3'd0; b8.Din = 16'h5555; b8.Clear = 1'b1; b8.SR1 = 3'd0;
    #1;
    n_cmp++;
    if (b8.Busy !== 1'b0) begin
      n_err++; $display("FAIL lc_busy_before got=%b exp=0", b8.Busy);
    end
    tick();
    b8.Load = 1'b0; b8.Clear = 1'b0;
    model8[0] = 16'h5555;
    #1;
    n_cmp++;
    if (b8.Busy !== 1'b1) begin
      n_err++; $display("FAIL lc_busy_rise got=%b exp=1", b8.Busy);
    end
    exp_q.push_back(model8[0]);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b8.SR1_out !== exp_v) begin
      n_err++; $display("FAIL lc_reg0_written got=%h exp=%h", b8.SR1_out, exp_v);
    end
    tick();
    model8[0] = 16'h0000;
    #1;
    exp_q.push_back(model8[0]);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b8.SR1_out !== exp_v) begin
      n_err++; $display("FAIL lc_reg0_swept got=%h exp=%h", b8.SR1_out, exp_v);
    end
    tick();
    tick();
    // Fourth Busy cycle: reset aborts the sweep at once.
    Reset_n = 1'b0;
    zero_models();
    #1;
    n_cmp++;
    if (b8.Busy !== 1'b0) begin
      n_err++; $display("FAIL abort_busy got=%b exp=0", b8.Busy);
    end
    for (int j = 0; j < 4; j++) begin
      b8.SR1 = 3'(2 * j); b8.SR2 = 3'(2 * j + 1);
      #1;
      exp_q.push_back(model8[2 * j]); exp_q.push_back(model8[2 * j + 1]);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (b8.SR1_out !== exp_v) begin
        n_err++; $display("FAIL abort_reg%0d got=%h exp=%h", 2 * j, b8.SR1_out, exp_v);
      end
      exp_v = exp_q.pop_front(); n_cmp++;
      if (b8.SR2_out !== exp_v) begin
        n_err++; $display("FAIL abort_reg%0d got=%h exp=%h", 2 * j + 1, b8.SR2_out, exp_v);
      end
    end
    Reset_n = 1'b1;
    tick();
    b8.Clear = 1'b1;
    tick();
    b8.Clear = 1'b0;
    n = 0;
    while (b8.Busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 8) begin
      n_err++; $display("FAIL restart_busy_cycles got=%0d exp=8", n);
    end
  endtask

  task automatic test_out_of_range();
    int n;
    for (int i = 0; i < 6; i++) wr6(i, 16'h6000 + 16'(i));
    b6.SR1 = 3'd5; b6.SR2 = 3'd7; b6.Load = 1'b1; b6.DR = 3'd7; b6.Din = 16'h7777;
    #1;
    n_cmp++;
    if (b6.Wr_drop !== 1'b1) begin
      n_err++; $display("FAIL oor_wr_drop7 got=%b exp=1", b6.Wr_drop);
    end
    exp_q.push_back(16'h0000); exp_q.push_back(model6[5]);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b6.SR2_out !== exp_v) begin
      n_err++; $display("FAIL oor_sr2_7 got=%h exp=%h", b6.SR2_out, exp_v);
    end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b6.SR1_out !== exp_v) begin
      n_err++; $display("FAIL oor_sr1_5 got=%h exp=%h", b6.SR1_out, exp_v);
    end
    tick();
    b6.DR = 3'd6; b6.SR2 = 3'd6;
    #1;
    n_cmp++;
    if (b6.Wr_drop !== 1'b1) begin
      n_err++; $display("FAIL oor_wr_drop6 got=%b exp=1", b6.Wr_drop);
    end
    exp_q.push_back(16'h0000);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b6.SR2_out !== exp_v) begin
      n_err++; $display("FAIL oor_sr2_6 got=%h exp=%h", b6.SR2_out, exp_v);
    end
    tick();
    b6.Load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b6.SR1 = 3'(i);
      #1;
      exp_q.push_back(model6[i]);
      exp_v = exp_q.pop_front(); n_cmp++;
      if (b6.SR1_out !== exp_v) begin
        n_err++; $display("FAIL oor_unchanged_reg%0d got=%h exp=%h", i, b6.SR1_out, exp_v);
      end
    end
    b6.Clear = 1'b1;
    tick();
    b6.Clear = 1'b0;
    n = 0;
    while (b6.Busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 6) begin
      n_err++; $display("FAIL depth6_busy_cycles got=%0d exp=6", n);
    end
    b6.SR1 = 3'd5;
    #1;
    exp_q.push_back(16'h0000);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (b6.SR1_out !== exp_v) begin
      n_err++; $display("FAIL depth6_last_cleared got=%h exp=%h", b6.SR1_out, exp_v);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Reset_n = 1'b0;
    b8.Load = 1'b0; b8.DR = '0; b8.Din = '0; b8.SR1 = '0; b8.SR2 = '0; b8.Clear = 1'b0;
    b6.Load = 1'b0; b6.DR = '0; b6.Din = '0; b6.SR1 = '0; b6.SR2 = '0; b6.Clear = 1'b0;
    zero_models();
    #12;
    Reset_n = 1'b1;
    tick();
    test_reset();
    test_write_read();
    test_bulk_clear();
    test_write_during_clear();
    test_load_and_clear();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
